sub_serial: RTL and testbench
=============================

// Module: sub_serial
//
// PURPOSE
//   Multi-cycle digit-serial subtractor for the ALU, the counterpart of the
//   registered 16-bit adder. It computes diff = a - b one DIGIT_W-bit slice per
//   clock, LSB slice first, using a start/done handshake. Alongside the
//   difference it produces borrow, zero, negative and signed-overflow flags for
//   the status register. It sits beside the adder in the ALU execute stage, and
//   the processor control FSM sequences it.
//
// PARAMETERS
//   WIDTH    16  operand and result width in bits
//   DIGIT_W   4  bits processed per cycle; WIDTH % DIGIT_W must be 0
//   N = WIDTH/DIGIT_W slice count (localparam, not overridable)
//
// PORTS
//   clk     in   1      system clock, rising edge
//   rst     in   1      asynchronous active-low reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  minuend; captured on the accepting edge
//   b       in   WIDTH  subtrahend; captured on the accepting edge
//   busy    out  1      high while state == RUN
//   done    out  1      one-cycle pulse; result and flags are valid
//   diff    out  WIDTH  a - b, modulo 2^WIDTH
//   borrow  out  1      1 when a < b (unsigned)
//   zero    out  1      1 when diff == 0
//   neg     out  1      diff[WIDTH-1]
//   ovf     out  1      signed overflow: (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB])
//
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, slice counter=0, borrow chain=0, all
//     outputs=0. A reset asserted mid-RUN aborts the operation. No done pulse
//     is produced and no partial result appears on diff.
//   - FSM states: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: if start=1 at an edge, latch a and b, clear cnt and the internal
//       borrow, and go to RUN. Otherwise stay in IDLE.
//     RUN: at each edge, compute slice cnt = a_r[cnt] - b_r[cnt] - brw in
//       DIGIT_W+1 bits. Store the low DIGIT_W bits into the internal
//       accumulator, set brw from the carry bit, and increment cnt. On the edge
//       that processes slice N-1, load diff and the flags from the completed
//       accumulator and go to DONE.
//     DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
//   - Latency: if start is accepted at edge E0, busy=1 from E0 to E0+N, and
//     done=1 in the cycle between E0+N and E0+N+1 (N=4 by default).
//     Throughput: one operation per N+2 cycles.
//   - start is ignored in RUN and DONE. It is not queued. Changes to a and b
//     after acceptance have no effect.
//   - diff and the flags hold their last value until the next operation's
//     DONE load. They never show partial slices.
//   - Arithmetic wraps modulo 2^WIDTH. The borrow output is the final borrow
//     out of the MSB slice. The zero flag ignores borrow.
//
// TESTING (default parameters unless noted)
//   1. a=0003, b=0004, start pulse -> done at E0+4; diff=FFFF, borrow=1,
//      neg=1, zero=0, ovf=0.
//   2. a=8000, b=0001 -> diff=7FFF, borrow=0, ovf=1, neg=0. Then a=7FFF,
//      b=FFFF -> diff=8000, ovf=1, borrow=1.
//   3. a=1234, b=1234 -> diff=0000, zero=1, borrow=0. Also a=0000, b=0000
//      gives the same result.
//   4. Hold start=1 for 8 cycles with new operands each cycle -> exactly one
//      operation using the first-cycle operands. The next operation is
//      accepted only after done falls.
//   5. Pulse rst low at E0+2 -> busy, done and diff read 0 immediately. No
//      done pulse follows. A new start then completes normally.
//   6. DIGIT_W=1 and DIGIT_W=16 builds -> done at E0+16 and E0+1. A 200-pair
//      random sweep matches a-b and all four flags.

Source files
------------

// File: rtl/sub_serial_if.sv
// Operand/result bundle for the digit-serial subtractor.
// The master drives the request; the slave returns status and result.
interface sub_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero, neg, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero, neg, ovf
  );
endinterface

// File: rtl/sub_serial.sv
// Digit-serial subtractor: diff = a - b, one DIGIT_W slice per clock, LSB first.
// Result and status flags only change on the final slice, so no partial value is ever visible.
module sub_serial #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  sub_serial_if.slave bus
);
  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               brw_reg;
  logic [DIGIT_W-1:0] acc_reg [N];
  logic [DIGIT_W-1:0] a_dig [N];
  logic [DIGIT_W-1:0] b_dig [N];
  logic [DIGIT_W-1:0] a_cur, b_cur;
  logic [DIGIT_W:0]   slice;
  logic [WIDTH-1:0]   acc_full;
  logic               last;

  logic [WIDTH-1:0]   diff_reg;
  logic               borrow_reg, zero_reg, neg_reg, ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dig
      assign a_dig[gi] = a_reg[gi*DIGIT_W +: DIGIT_W];
      assign b_dig[gi] = b_reg[gi*DIGIT_W +: DIGIT_W];
      // The slice being processed this cycle is spliced in so the final load sees all digits.
      assign acc_full[gi*DIGIT_W +: DIGIT_W] =
        (cnt_reg == CNT_W'(gi)) ? slice[DIGIT_W-1:0] : acc_reg[gi];
    end
    if (N == 1) begin : g_sel_one
      assign a_cur = a_dig[0];
      assign b_cur = b_dig[0];
    end else begin : g_sel_many
      assign a_cur = a_dig[cnt_reg];
      assign b_cur = b_dig[cnt_reg];
    end
  endgenerate

  assign slice = {1'b0, a_cur} - {1'b0, b_cur} - {{DIGIT_W{1'b0}}, brw_reg};
  assign last  = (cnt_reg == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      brw_reg    <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      for (int i = 0; i < N; i++) acc_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            cnt_reg <= '0;
            brw_reg <= 1'b0;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++)
            if (cnt_reg == CNT_W'(i)) acc_reg[i] <= slice[DIGIT_W-1:0];
          brw_reg <= slice[DIGIT_W];
          cnt_reg <= cnt_reg + 1'b1;
          if (last) begin
            diff_reg   <= acc_full;
            borrow_reg <= slice[DIGIT_W];
            zero_reg   <= (acc_full == '0);
            neg_reg    <= acc_full[MSB];
            ovf_reg    <= (a_reg[MSB] ^ b_reg[MSB]) & (acc_full[MSB] ^ a_reg[MSB]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = (state_reg == DONE);
  assign bus.diff   = diff_reg;
  assign bus.borrow = borrow_reg;
  assign bus.zero   = zero_reg;
  assign bus.neg    = neg_reg;
  assign bus.ovf    = ovf_reg;
endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: directed vectors, handshake corner cases and a random sweep
// on three builds (DIGIT_W = 4, 1, 16) against an arithmetic reference model.
module tb_sub_serial;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_v  [3];
  logic [15:0] a_v      [3];
  logic [15:0] b_v      [3];
  logic        busy_v   [3];
  logic        done_v   [3];
  logic [15:0] diff_v   [3];
  logic        borrow_v [3];
  logic        zero_v   [3];
  logic        neg_v    [3];
  logic        ovf_v    [3];

  int lat_c [3] = '{4, 16, 1};
  int checks = 0;
  int errors = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int DW = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
      sub_serial_if #(.WIDTH(16)) bus ();
      assign bus.start    = start_v[gi];
      assign bus.a        = a_v[gi];
      assign bus.b        = b_v[gi];
      assign busy_v[gi]   = bus.busy;
      assign done_v[gi]   = bus.done;
      assign diff_v[gi]   = bus.diff;
      assign borrow_v[gi] = bus.borrow;
      assign zero_v[gi]   = bus.zero;
      assign neg_v[gi]    = bus.neg;
      assign ovf_v[gi]    = bus.ovf;
      sub_serial #(.WIDTH(16), .DIGIT_W(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        neg;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
    vec_t r;
    int ud, sd;
    logic [31:0] udv;
    ud  = int'(a) - int'(b);
    sd  = int'($signed(a)) - int'($signed(b));
    udv = ud;
    r.a      = a;
    r.b      = b;
    r.diff   = udv[15:0];
    r.borrow = (ud < 0);
    r.zero   = (r.diff == 16'h0000);
    r.neg    = r.diff[15];
    r.ovf    = (sd > 32767) || (sd < -32768);
    return r;
  endfunction

  task automatic compare(input int k, input string tag, input vec_t exp);
    check($sformatf("%s.diff[%0d]", tag, k),   32'(diff_v[k]),   32'(exp.diff));
    check($sformatf("%s.borrow[%0d]", tag, k), 32'(borrow_v[k]), 32'(exp.borrow));
    check($sformatf("%s.zero[%0d]", tag, k),   32'(zero_v[k]),   32'(exp.zero));
    check($sformatf("%s.neg[%0d]", tag, k),    32'(neg_v[k]),    32'(exp.neg));
    check($sformatf("%s.ovf[%0d]", tag, k),    32'(ovf_v[k]),    32'(exp.ovf));
  endtask

  // One full operation; operands are scrambled right after acceptance.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input vec_t exp,
                        input string tag);
    int cyc;
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0; a_v[k] = 16'($urandom); b_v[k] = 16'($urandom);
    check($sformatf("%s.busy[%0d]", tag, k), 32'(busy_v[k]), 32'd1);
    cyc = 0;
    while (!done_v[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s.latency[%0d]", tag, k), 32'(cyc), 32'(lat_c[k]));
    compare(k, tag, exp);
    @(posedge clk); #1;
    check($sformatf("%s.done_fall[%0d]", tag, k), 32'({done_v[k], busy_v[k]}), 32'd0);
    check($sformatf("%s.hold[%0d]", tag, k), 32'(diff_v[k]), 32'(exp.diff));
    $display("op k=%0d %s a=%h b=%h diff=%h lat=%0d", k, tag, a, b, diff_v[k], cyc);
  endtask

  vec_t        tbl [7];
  logic [15:0] ha  [8];
  logic [15:0] hb  [8];

  initial begin
    vec_t e;
    int ndone, cyc;
    logic [15:0] ra, rb;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; a_v[k] = 16'h0; b_v[k] = 16'h0;
    end

    tbl[0] = '{16'h0003, 16'h0004, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst.ctl[%0d]", k), 32'({busy_v[k], done_v[k]}), 32'd0);
      check($sformatf("rst.out[%0d]", k),
            32'({diff_v[k], borrow_v[k], zero_v[k], neg_v[k], ovf_v[k]}), 32'd0);
    end
    @(negedge clk); rst = 1'b1;

    // Directed vectors on every build
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 7; i++)
        run_op(k, tbl[i].a, tbl[i].b, tbl[i], $sformatf("vec%0d", i));

    // start held for 8 cycles with changing operands
    for (int i = 0; i < 8; i++) begin
      ha[i] = 16'(i * 16'h1111 + 16'h0500);
      hb[i] = 16'(i * 16'h0202 + 16'h0011);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_v[0] = 1'b1; a_v[0] = ha[i]; b_v[0] = hb[i];
      @(posedge clk); #1;
      if (done_v[0]) begin
        ndone++;
        compare(0, "hold1", model(ha[0], hb[0]));
      end
      if (i == 5) check("hold.idle_gap", 32'(busy_v[0]), 32'd0);
      if (i == 6) check("hold.reaccept", 32'(busy_v[0]), 32'd1);
    end
    @(negedge clk); start_v[0] = 1'b0;
    check("hold.ndone", 32'(ndone), 32'd1);
    cyc = 0;
    while (!done_v[0] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold2.latency", 32'(cyc), 32'd3);
    compare(0, "hold2", model(ha[6], hb[6]));
    $display("hold sequence: dones=%0d second diff=%h", ndone, diff_v[0]);

    // Reset two edges into an operation
    @(negedge clk);
    a_v[0] = 16'h0100; b_v[0] = 16'h0001; start_v[0] = 1'b1;
    @(posedge clk); #1; start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort.ctl", 32'({busy_v[0], done_v[0]}), 32'd0);
    check("abort.diff", 32'(diff_v[0]), 32'd0);
    @(negedge clk); rst = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_v[0]) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    $display("abort sequence: spurious dones=%0d", ndone);
    run_op(0, 16'hABCD, 16'h1234, model(16'hABCD, 16'h1234), "post_abort");

    // Random sweep on each build
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 200; n++) begin
        ra = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
        rb = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
        if ($urandom_range(0, 15) == 0) rb = ra;
        e = model(ra, rb);
        run_op(k, ra, rb, e, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
